// File: rtl/punc_control1_pkg.sv
// Shared defines for the PUNC controller: state encodings, opcodes, mux selects,
// ALU and sign-extension selects, and the control word passed from decode to top.
package punc_control1_pkg;

    typedef enum logic [2:0] {
        StInit     = 3'd0,
        StFetch    = 3'd1,
        StDecode   = 3'd2,
        StExecute  = 3'd3,
        StExecute2 = 3'd4,
        StHalt     = 3'd5
    } state_e;

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpLd   = 4'b0010;
    localparam logic [3:0] OpSt   = 4'b0011;
    localparam logic [3:0] OpJsr  = 4'b0100;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpLdr  = 4'b0110;
    localparam logic [3:0] OpStr  = 4'b0111;
    localparam logic [3:0] OpRsv8 = 4'b1000;
    localparam logic [3:0] OpNot  = 4'b1001;
    localparam logic [3:0] OpLdi  = 4'b1010;
    localparam logic [3:0] OpSti  = 4'b1011;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpRsvD = 4'b1101;
    localparam logic [3:0] OpLea  = 4'b1110;
    localparam logic [3:0] OpHalt = 4'b1111;

    localparam logic [2:0] MemAddrPc       = 3'd0;
    localparam logic [2:0] MemAddrPcAdder  = 3'd1;
    localparam logic [2:0] MemAddrIndirect = 3'd2;
    localparam logic [2:0] MemAddrRData    = 3'd3;
    localparam logic [2:0] MemAddrAluC     = 3'd4;

    localparam logic [1:0] RfWdAluC    = 2'd0;
    localparam logic [1:0] RfWdPc      = 2'd1;
    localparam logic [1:0] RfWdMem     = 2'd2;
    localparam logic [1:0] RfWdPcAdder = 2'd3;

    localparam logic [1:0] AluPass = 2'd0;
    localparam logic [1:0] AluAdd  = 2'd1;
    localparam logic [1:0] AluAnd  = 2'd2;
    localparam logic [1:0] AluNot  = 2'd3;

    localparam logic [3:0] SextImm5  = 4'b1000;
    localparam logic [3:0] SextOff6  = 4'b0100;
    localparam logic [3:0] SextOff9  = 4'b0010;
    localparam logic [3:0] SextOff11 = 4'b0001;

    typedef struct packed {
        logic        mem_wr_en;
        logic [2:0]  mem_r_addr_sel;
        logic        state2_sti;
        logic        str;
        logic [2:0]  rf_wr_addr;
        logic [2:0]  rf_r_addr_0;
        logic [2:0]  rf_r_addr_1;
        logic        rf_wr_en;
        logic [1:0]  rf_w_data_sel;
        logic        ir_ld;
        logic        pc_ld;
        logic        pc_clr;
        logic        pc_up;
        logic        jmp_ret_jsrr;
        logic        add_const;
        logic [1:0]  alu_sel;
        logic        cc_en;
        logic        n;
        logic        z;
        logic        p;
        logic [10:0] const_n;
        logic [3:0]  sext_select;
    } ctrl_t;

    // LDI and STI need a second execute cycle for the indirect access.
    function automatic logic needs_execute2(logic [3:0] opcode);
        return (opcode == OpLdi) || (opcode == OpSti);
    endfunction

endpackage

// File: rtl/punc_ctrl_decode.sv
// Combinational control-word decode for the PUNC controller: (state, ir) -> control word.
// All controls are held at zero while rst is high so no write can escape a reset cycle.
module punc_ctrl_decode
    import punc_control1_pkg::*;
(
    input  state_e      state,
    input  logic        rst,
    input  logic [15:0] ir,
    output ctrl_t       ctrl
);

    logic [3:0] opcode;
    assign opcode = ir[15:12];

    // Output decode; anything not driven for a state stays zero.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl.const_n = ir[10:0];
            case (state)
                StInit: ctrl.pc_clr = 1'b1;
                StFetch: begin
                    ctrl.mem_r_addr_sel = MemAddrPc;
                    ctrl.ir_ld          = 1'b1;
                    ctrl.pc_up          = 1'b1;
                end
                StExecute: begin
                    case (opcode)
                        OpAdd, OpAnd, OpNot: begin
                            ctrl.rf_wr_en      = 1'b1;
                            ctrl.rf_wr_addr    = ir[11:9];
                            ctrl.rf_r_addr_0   = ir[8:6];
                            ctrl.rf_r_addr_1   = ir[2:0];
                            ctrl.add_const     = (opcode == OpNot) ? 1'b0 : ir[5];
                            ctrl.sext_select   = SextImm5;
                            ctrl.alu_sel       = (opcode == OpAdd) ? AluAdd :
                                                 (opcode == OpAnd) ? AluAnd : AluNot;
                            ctrl.rf_w_data_sel = RfWdAluC;
                            ctrl.cc_en         = 1'b1;
                        end
                        OpBr: begin
                            // Taken/not-taken is resolved by the datapath CC logic.
                            {ctrl.n, ctrl.z, ctrl.p} = ir[11:9];
                            ctrl.sext_select         = SextOff9;
                        end
                        OpJmp: begin
                            ctrl.rf_r_addr_0  = ir[8:6];
                            ctrl.alu_sel      = AluPass;
                            ctrl.jmp_ret_jsrr = 1'b1;
                            ctrl.pc_ld        = 1'b1;
                        end
                        OpJsr: begin
                            ctrl.rf_wr_en      = 1'b1;
                            ctrl.rf_wr_addr    = 3'd7;
                            ctrl.rf_w_data_sel = RfWdPc;
                            ctrl.pc_ld         = 1'b1;
                            if (ir[11]) begin
                                ctrl.sext_select = SextOff11;
                            end else begin
                                ctrl.rf_r_addr_0  = ir[8:6];
                                ctrl.alu_sel      = AluPass;
                                ctrl.jmp_ret_jsrr = 1'b1;
                            end
                        end
                        OpLd: begin
                            ctrl.mem_r_addr_sel = MemAddrPcAdder;
                            ctrl.sext_select    = SextOff9;
                            ctrl.rf_w_data_sel  = RfWdMem;
                            ctrl.rf_wr_en       = 1'b1;
                            ctrl.rf_wr_addr     = ir[11:9];
                        end
                        OpLdr: begin
                            ctrl.mem_r_addr_sel = MemAddrAluC;
                            ctrl.rf_r_addr_0    = ir[8:6];
                            ctrl.add_const      = 1'b1;
                            ctrl.sext_select    = SextOff6;
                            ctrl.alu_sel        = AluAdd;
                            ctrl.rf_w_data_sel  = RfWdMem;
                            ctrl.rf_wr_en       = 1'b1;
                            ctrl.rf_wr_addr     = ir[11:9];
                        end
                        OpLdi, OpSti: begin
                            // First half of an indirect access: fetch the pointer.
                            ctrl.mem_r_addr_sel = MemAddrPcAdder;
                            ctrl.sext_select    = SextOff9;
                        end
                        OpLea: begin
                            ctrl.sext_select   = SextOff9;
                            ctrl.rf_w_data_sel = RfWdPcAdder;
                            ctrl.rf_wr_en      = 1'b1;
                            ctrl.rf_wr_addr    = ir[11:9];
                        end
                        OpSt: begin
                            ctrl.mem_wr_en   = 1'b1;
                            ctrl.sext_select = SextOff9;
                            ctrl.rf_r_addr_0 = ir[11:9];
                            ctrl.alu_sel     = AluPass;
                        end
                        OpStr: begin
                            ctrl.str         = 1'b1;
                            ctrl.mem_wr_en   = 1'b1;
                            ctrl.rf_r_addr_0 = ir[8:6];
                            ctrl.rf_r_addr_1 = ir[11:9];
                            ctrl.add_const   = 1'b1;
                            ctrl.sext_select = SextOff6;
                            ctrl.alu_sel     = AluAdd;
                        end
                        OpRsv8, OpRsvD: ;
                        default: ;
                    endcase
                end
                StExecute2: begin
                    if (opcode == OpLdi) begin
                        ctrl.mem_r_addr_sel = MemAddrIndirect;
                        ctrl.rf_w_data_sel  = RfWdMem;
                        ctrl.rf_wr_en       = 1'b1;
                        ctrl.rf_wr_addr     = ir[11:9];
                    end else if (opcode == OpSti) begin
                        ctrl.state2_sti  = 1'b1;
                        ctrl.mem_wr_en   = 1'b1;
                        ctrl.rf_r_addr_0 = ir[11:9];
                        ctrl.alu_sel     = AluPass;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/punc_control1.sv
// PUNC controller top: state register and next-state logic; outputs come from
// punc_ctrl_decode. Define PUNC_CTRL_STATE_DEBUG_EN to expose state_debug[2:0].
module punc_control1
    import punc_control1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    output logic        mem_wr_en,
    output logic [2:0]  mem_r_addr_sel,
    output logic        state2_STI,
    output logic        STR,
    output logic [2:0]  RF_wr_addr,
    output logic [2:0]  RF_r_addr_0,
    output logic [2:0]  RF_r_addr_1,
    output logic        RF_wr_en,
    output logic [1:0]  RF_w_data_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        JMP_RET_JSRR,
    output logic        add_const,
    output logic [1:0]  alu_sel,
    output logic        cc_en,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [10:0] const_n,
`ifdef PUNC_CTRL_STATE_DEBUG_EN
    output logic [2:0]  state_debug,
`endif
    output logic [3:0]  SEXT_Select
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StInit;
        else     state_q <= state_d;
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:     state_d = StFetch;
            StFetch:    state_d = StDecode;
            StDecode:   state_d = (ir[15:12] == OpHalt) ? StHalt : StExecute;
            StExecute:  state_d = needs_execute2(ir[15:12]) ? StExecute2 : StFetch;
            StExecute2: state_d = StFetch;
            StHalt:     state_d = StHalt;
            default:    state_d = StInit;
        endcase
    end

    punc_ctrl_decode u_decode (
        .state (state_q),
        .rst   (rst),
        .ir    (ir),
        .ctrl  (ctrl)
    );

    assign mem_wr_en      = ctrl.mem_wr_en;
    assign mem_r_addr_sel = ctrl.mem_r_addr_sel;
    assign state2_STI     = ctrl.state2_sti;
    assign STR            = ctrl.str;
    assign RF_wr_addr     = ctrl.rf_wr_addr;
    assign RF_r_addr_0    = ctrl.rf_r_addr_0;
    assign RF_r_addr_1    = ctrl.rf_r_addr_1;
    assign RF_wr_en       = ctrl.rf_wr_en;
    assign RF_w_data_sel  = ctrl.rf_w_data_sel;
    assign ir_ld          = ctrl.ir_ld;
    assign pc_ld          = ctrl.pc_ld;
    assign pc_clr         = ctrl.pc_clr;
    assign pc_up          = ctrl.pc_up;
    assign JMP_RET_JSRR   = ctrl.jmp_ret_jsrr;
    assign add_const      = ctrl.add_const;
    assign alu_sel        = ctrl.alu_sel;
    assign cc_en          = ctrl.cc_en;
    assign n              = ctrl.n;
    assign z              = ctrl.z;
    assign p              = ctrl.p;
    assign const_n        = ctrl.const_n;
    assign SEXT_Select    = ctrl.sext_select;

`ifdef PUNC_CTRL_STATE_DEBUG_EN
    assign state_debug = state_q;
`endif

endmodule

// File: doc/punc_control1.md
PUNC_CONTROL1 -- requirements
Module: punc_control1

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 ir  in  16  instruction register contents from the datapath; opcode is ir[15:12].
REQ-003 The module SHALL drive these memory controls: mem_wr_en  out  1; mem_r_addr_sel  out  3  (0 pc, 1 pc_adder, 2 indirect, 3 mem_r_data, 4 alu_c); state2_STI  out  1; STR  out  1.
REQ-004 The module SHALL drive these register-file controls: RF_wr_addr, RF_r_addr_0, RF_r_addr_1  out  3 each; RF_wr_en  out  1; RF_w_data_sel  out  2  (0 alu_c, 1 pc, 2 mem_r_data, 3 pc_adder).
REQ-005 The module SHALL drive these PC/IR controls: ir_ld, pc_ld, pc_clr, pc_up, JMP_RET_JSRR  out  1 each.
REQ-006 The module SHALL drive these ALU/CC/SEXT controls: add_const  out  1; alu_sel  out  2  (0 PASS, 1 ADD, 2 AND, 3 NOT); cc_en, n, z, p  out  1 each; const_n  out  11, always ir[10:0]; SEXT_Select  out  4  (1000 imm5, 0100 off6, 0010 off9, 0001 off11).

Function
REQ-007 The FSM SHALL have exactly these states: INIT, FETCH, DECODE, EXECUTE, EXECUTE2, HALT.
REQ-008 Outputs SHALL be combinational from state and ir; every output not listed for a state SHALL be 0.
REQ-009 INIT SHALL assert pc_clr for one cycle and then go to FETCH.
REQ-010 FETCH SHALL drive mem_r_addr_sel=0, ir_ld=1 and pc_up=1, then go to DECODE.
REQ-011 DECODE SHALL assert no outputs; it SHALL go to HALT if the opcode is 1111, otherwise to EXECUTE.
REQ-012 EXECUTE SHALL go to EXECUTE2 for LDI (1010) and STI (1011), otherwise to FETCH; EXECUTE2 SHALL always go to FETCH.
REQ-013 For ADD (0001) and AND (0101), EXECUTE SHALL drive: RF_wr_en=1; RF_wr_addr=ir[11:9]; RF_r_addr_0=ir[8:6]; RF_r_addr_1=ir[2:0]; add_const=ir[5]; SEXT_Select=1000; alu_sel ADD or AND; RF_w_data_sel=0; cc_en=1.
REQ-014 For NOT (1001), EXECUTE SHALL match REQ-013 except alu_sel=NOT and add_const=0.
REQ-015 For BR (0000), EXECUTE SHALL drive n/z/p=ir[11:9], SEXT_Select=0010 and JMP_RET_JSRR=0, with pc_ld=0; the datapath's CC logic decides whether the branch is taken.
REQ-016 For JMP (1100), EXECUTE SHALL drive RF_r_addr_0=ir[8:6], alu_sel=PASS, JMP_RET_JSRR=1 and pc_ld=1.
REQ-017 For JSR/JSRR (0100), EXECUTE SHALL drive RF_wr_en=1, RF_wr_addr=7, RF_w_data_sel=1 and pc_ld=1.
  - If ir[11]=1: SEXT_Select=0001 and JMP_RET_JSRR=0.
  - If ir[11]=0: RF_r_addr_0=ir[8:6], alu_sel=PASS and JMP_RET_JSRR=1; base R7 uses the pre-write R7 value.
REQ-018 For LD (0010), EXECUTE SHALL drive mem_r_addr_sel=1, SEXT_Select=0010, RF_w_data_sel=2, RF_wr_en=1 and RF_wr_addr=ir[11:9]; CC is unchanged.
REQ-019 For LDR (0110), EXECUTE SHALL drive mem_r_addr_sel=4, RF_r_addr_0=ir[8:6], add_const=1, SEXT_Select=0100, alu_sel=ADD, RF_w_data_sel=2, RF_wr_en=1 and RF_wr_addr=ir[11:9].
REQ-020 For LDI (1010), EXECUTE SHALL drive mem_r_addr_sel=1 and SEXT_Select=0010; EXECUTE2 SHALL drive mem_r_addr_sel=2, RF_w_data_sel=2, RF_wr_en=1 and RF_wr_addr=ir[11:9].
REQ-021 For LEA (1110), EXECUTE SHALL drive SEXT_Select=0010, RF_w_data_sel=3, RF_wr_en=1 and RF_wr_addr=ir[11:9].
REQ-022 For ST (0011), EXECUTE SHALL drive mem_wr_en=1, SEXT_Select=0010, RF_r_addr_0=ir[11:9] and alu_sel=PASS.
REQ-023 For STR (0111), EXECUTE SHALL drive STR=1, mem_wr_en=1, RF_r_addr_0=ir[8:6], RF_r_addr_1=ir[11:9], add_const=1, SEXT_Select=0100 and alu_sel=ADD.
REQ-024 For STI (1011), EXECUTE SHALL drive mem_r_addr_sel=1 and SEXT_Select=0010; EXECUTE2 SHALL drive state2_STI=1, mem_wr_en=1, RF_r_addr_0=ir[11:9] and alu_sel=PASS.
REQ-025 Opcodes 1000 and 1101 SHALL execute as a NOP: no outputs asserted, then FETCH.
REQ-026 HALT SHALL assert no outputs and SHALL remain in HALT until rst.
REQ-027 Every instruction SHALL take 3 cycles, except LDI/STI (4 cycles) and HALT (terminal).

Reset
REQ-028 When rst is high at a clock edge, the next state SHALL be INIT, regardless of current state.
REQ-029 While rst is high, all outputs SHALL be forced to 0; this includes any in-flight write cycle.
REQ-030 In the first cycle after rst deasserts, only pc_clr SHALL be 1.

Configuration
REQ-031 When macro PUNC_CTRL_STATE_DEBUG_EN is defined, the module SHALL add output state_debug[2:0] carrying the state encoding: INIT 0, FETCH 1, DECODE 2, EXECUTE 3, EXECUTE2 4, HALT 5.
REQ-032 When PUNC_CTRL_STATE_DEBUG_EN is undefined, the state_debug port SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Opcode constants, state encodings, and mux-select/ALU/SEXT constants SHALL reside in the shared defines package alongside the existing datapath defines.
REQ-034 The block SHALL contain one combinational sub-module, punc_ctrl_decode, mapping (state, ir) to the control word; punc_control1 holds only the state register and next-state logic.

Verification
REQ-035 Reset then release -> one INIT cycle with pc_clr=1, then FETCH with ir_ld=1, pc_up=1, mem_r_addr_sel=0.
REQ-036 ir=16'h1283 (ADD R1,R2,R3) in EXECUTE -> RF_wr_addr=1, RF_r_addr_0=2, RF_r_addr_1=3, add_const=0, alu_sel=1, cc_en=1; next state FETCH.
REQ-037 ir=16'hA605 (LDI R3,#5) -> EXECUTE mem_r_addr_sel=1; EXECUTE2 mem_r_addr_sel=2, RF_wr_en=1, RF_wr_addr=3; total 4 cycles.
REQ-038 ir=16'h4080 (JSRR R2) -> RF_wr_addr=7, RF_w_data_sel=1, pc_ld=1, JMP_RET_JSRR=1, RF_r_addr_0=2.
REQ-039 ir=16'hF025 -> HALT reached after DECODE; stays in HALT for 100 cycles; rst returns the FSM to INIT.
REQ-040 rst asserted during STI EXECUTE2 -> mem_wr_en=0 in that cycle; next state INIT.
